// File: rtl/cla_shift_add_mult.sv
`default_nettype none
// ============================================================================
//  Module   : ffulladd_cla, cla_shift_add_mult
//  Purpose  : ffulladd_cla is a 4-bit carry-lookahead adder slice.
//             cla_shift_add_mult is a sequential unsigned shift-add
//             multiplier. It consumes one multiplier bit per clock and
//             time-shares a chain of ffulladd_cla slices for the
//             partial-product accumulation.
//  Revision : 1.0 - initial release
// ============================================================================

module ffulladd_cla (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:1] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Every carry is formed directly from the generate/propagate terms, so
    // there is no ripple path inside the slice.
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_sum  = w_p ^ {w_c[3:1], i_cin};
    assign o_cout = w_c[4];

endmodule

module cla_shift_add_mult #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int c_NUM_CLA = WIDTH / 4;
    localparam int c_CNT_W   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    // Reject widths the 4-bit slice chain cannot cover exactly.
    generate
        if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
            $error("cla_shift_add_mult: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WIDTH-1:0]       r_mcand;
    logic [2*WIDTH:0]       r_work;     // {carry, hi, lo}
    logic [c_CNT_W-1:0]     r_cnt;

    logic [WIDTH-1:0]       w_hi;
    logic [WIDTH-1:0]       w_lo;
    logic [WIDTH-1:0]       w_addend;
    logic [WIDTH-1:0]       w_sum;
    logic [c_NUM_CLA:0]     w_carry;
    logic [2*WIDTH:0]       w_step;
    logic                   w_last;
    logic                   w_unused_carry;

    assign w_hi     = r_work[2*WIDTH-1:WIDTH];
    assign w_lo     = r_work[WIDTH-1:0];
    assign w_addend = w_lo[0] ? r_mcand : '0;
    assign w_carry[0] = 1'b0;

    // The carry slot is always zero after a shift; the carry of each add is
    // folded straight into the top of hi instead.
    assign w_unused_carry = r_work[2*WIDTH];

    generate
        for (genvar gi = 0; gi < c_NUM_CLA; gi++) begin : g_cla
            ffulladd_cla u_cla (
                .i_a    (w_hi[4*gi +: 4]),
                .i_b    (w_addend[4*gi +: 4]),
                .i_cin  (w_carry[gi]),
                .o_sum  (w_sum[4*gi +: 4]),
                .o_cout (w_carry[gi+1])
            );
        end
    endgenerate

    // {cout, sum, lo} shifted right by one: the consumed multiplier bit drops
    // out of lo and the adder carry lands in the MSB of hi.
    assign w_step = {1'b0, w_carry[c_NUM_CLA], w_sum, w_lo[WIDTH-1:1]};
    assign w_last = (r_cnt == c_CNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; abort only matters while running.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand capture, per-bit accumulate/shift, and product commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand <= '0;
            r_work  <= '0;
            r_cnt   <= '0;
            p       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mcand <= a;
                        r_work  <= {1'b0, {WIDTH{1'b0}}, b};
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_work <= '0;
                        r_cnt  <= '0;
                    end else begin
                        r_work <= w_step;
                        if (w_last) begin
                            p <= w_step[2*WIDTH-1:0];
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready = (r_state == ST_IDLE);
    assign busy  = (r_state == ST_RUN);
    assign done  = (r_state == ST_DONE);

endmodule
`default_nettype wire
